spdif_subframe_assembler: RTL and testbench

- Sits directly downstream of the biphase-mark decoder and consumes its per-bit stream `vin`/`din`, plus its `channel` and `frame_counter` outputs.
- Rebuilds each 28-bit subframe and checks even parity.
- Pairs each left (A) subframe with the right (B) subframe that follows it into a stereo sample.
- Collects channel-status (C) bits from left subframes into a status word for the control logic.

---
 rtl/spdif_pkg.sv | 22 ++
 rtl/spdif_subframe_collector.sv | 73 +++++++
 rtl/spdif_subframe_assembler.sv | 119 +++++++++++
 tb/tb_spdif_subframe_assembler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared S/PDIF subframe layout constants and the decoded-subframe record
// passed from the collector to the pairing logic.
package spdif_pkg;

    localparam int SUBFRAME_BITS = 28;
    localparam int AUX_LSB       = 0;
    localparam int AUDIO_LSB     = 4;
    localparam int SAMPLE_W      = 24;
    localparam int V_POS         = 24;
    localparam int U_POS         = 25;
    localparam int C_POS         = 26;
    localparam int P_POS         = 27;

    typedef struct packed {
        logic [SAMPLE_W-1:0] sample;
        logic                v;
        logic                u;
        logic                c;
        logic                parity_ok;
    } subframe_t;

endpackage

// File: rtl/spdif_subframe_collector.sv
// Rebuilds one subframe from the decoder bit stream: boundary detection,
// LSB-first bit capture, even-parity check and short-subframe detection.
module spdif_subframe_collector
    import spdif_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_vin,
    input  logic       i_din,
    input  logic       i_channel,
    input  logic [7:0] i_frame_counter,
    output subframe_t  o_sf,
    output logic       o_done,
    output logic       o_channel,
    output logic [7:0] o_frame,
    output logic       o_short
);

    localparam logic [4:0] IDX_LAST = 5'(SUBFRAME_BITS - 1);
    localparam logic [4:0] IDX_SAT  = 5'(SUBFRAME_BITS);

    logic [4:0]               r_bit_idx;
    logic [SUBFRAME_BITS-1:0] r_shift;
    logic                     r_last_channel;
    logic [7:0]               r_sf_frame;

    logic                     w_boundary;
    logic                     w_accept;
    logic [SUBFRAME_BITS-1:0] w_full;

    assign w_boundary = (i_channel != r_last_channel);
    assign w_accept   = i_vin && !w_boundary && (r_bit_idx < IDX_SAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx      <= '0;
            r_shift        <= '0;
            r_last_channel <= 1'b0;
            r_sf_frame     <= '0;
        end else begin
            r_last_channel <= i_channel;
            if (w_boundary) begin
                r_sf_frame <= i_frame_counter;
                // A bit arriving with the channel change is the first bit of the new subframe.
                if (i_vin) begin
                    r_shift[0] <= i_din;
                    r_bit_idx  <= 5'd1;
                end else begin
                    r_bit_idx  <= 5'd0;
                end
            end else if (w_accept) begin
                r_shift[r_bit_idx] <= i_din;
                r_bit_idx          <= r_bit_idx + 5'd1;
            end
        end
    end

    always_comb begin
        w_full                  = r_shift;
        w_full[P_POS]           = i_din;
        o_sf.sample             = w_full[SAMPLE_W-1:0];
        o_sf.v                  = w_full[V_POS];
        o_sf.u                  = w_full[U_POS];
        o_sf.c                  = w_full[C_POS];
        o_sf.parity_ok          = ~^w_full;
    end

    assign o_done    = w_accept && (r_bit_idx == IDX_LAST);
    assign o_channel = r_last_channel;
    assign o_frame   = r_sf_frame;
    assign o_short   = w_boundary && (r_bit_idx != 5'd0) && (r_bit_idx != IDX_SAT);

endmodule

// File: rtl/spdif_subframe_assembler.sv
// Pairs left/right subframes into stereo samples and gathers channel-status
// bits from left subframes into a block-wide status word.
module spdif_subframe_assembler
    import spdif_pkg::*;
#(
    parameter int CS_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vin,
    input  logic                din,
    input  logic                channel,
    input  logic [7:0]          frame_counter,
    output logic [23:0]         sample_l,
    output logic [23:0]         sample_r,
    output logic [1:0]          validity,
    output logic [1:0]          user,
    output logic                parity_err,
    output logic                vout,
    output logic                framing_err,
    output logic [CS_BITS-1:0]  cs_word,
    output logic                cs_valid
);

    localparam logic [8:0] CS_LAST = 9'(CS_BITS - 1);

    subframe_t    w_sf;
    logic         w_done;
    logic         w_ch;
    logic [7:0]   w_frame;
    logic         w_short;
    logic         w_cs_last;
    logic [CS_BITS-1:0] w_cs_next;

    logic         r_left_held;
    logic [23:0]  r_left_sample;
    logic         r_left_v;
    logic         r_left_u;
    logic         r_left_perr;
    logic [CS_BITS-1:0] r_cs_shift;

    spdif_subframe_collector u_collector (
        .clk             (clk),
        .rst             (rst),
        .i_vin           (vin),
        .i_din           (din),
        .i_channel       (channel),
        .i_frame_counter (frame_counter),
        .o_sf            (w_sf),
        .o_done          (w_done),
        .o_channel       (w_ch),
        .o_frame         (w_frame),
        .o_short         (w_short)
    );

    // Frames at or beyond CS_BITS match no position and leave the word untouched.
    always_comb begin
        w_cs_next = r_cs_shift;
        for (int i = 0; i < CS_BITS; i++) begin
            if (w_frame == 8'(i)) begin
                w_cs_next[i] = w_sf.c;
            end
        end
    end

    assign w_cs_last = ({1'b0, w_frame} == CS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_l      <= '0;
            sample_r      <= '0;
            validity      <= '0;
            user          <= '0;
            parity_err    <= 1'b0;
            vout          <= 1'b0;
            framing_err   <= 1'b0;
            cs_word       <= '0;
            cs_valid      <= 1'b0;
            r_left_held   <= 1'b0;
            r_left_sample <= '0;
            r_left_v      <= 1'b0;
            r_left_u      <= 1'b0;
            r_left_perr   <= 1'b0;
            r_cs_shift    <= '0;
        end else begin
            vout        <= 1'b0;
            cs_valid    <= 1'b0;
            framing_err <= w_short;

            if (w_done && !w_ch) begin
                r_left_sample <= w_sf.sample;
                r_left_v      <= w_sf.v;
                r_left_u      <= w_sf.u;
                r_left_perr   <= !w_sf.parity_ok;
                r_left_held   <= 1'b1;
                r_cs_shift    <= w_cs_next;
                if (w_cs_last) begin
                    cs_word  <= w_cs_next;
                    cs_valid <= 1'b1;
                end
            end

            if (w_done && w_ch) begin
                if (r_left_held) begin
                    sample_l    <= r_left_sample;
                    sample_r    <= w_sf.sample;
                    validity    <= {w_sf.v, r_left_v};
                    user        <= {w_sf.u, r_left_u};
                    parity_err  <= r_left_perr || !w_sf.parity_ok;
                    vout        <= 1'b1;
                    r_left_held <= 1'b0;
                end else begin
                    framing_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_subframe_assembler.sv
// Directed bench for the subframe assembler: pairing, parity, framing errors,
// channel-status collection and mid-subframe reset.
module tb_spdif_subframe_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin;
    logic        din;
    logic        channel;
    logic [7:0]  frame_counter;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic [1:0]  validity;
    logic [1:0]  user;
    logic        parity_err;
    logic        vout;
    logic        framing_err;
    logic [31:0] cs_word;
    logic        cs_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int n_vout   = 0;
    int n_ferr   = 0;
    int n_csv    = 0;
    int e_v;
    int e_f;
    int e_c;
    logic [31:0] cs_pat;

    spdif_subframe_assembler #(.CS_BITS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .vin           (vin),
        .din           (din),
        .channel       (channel),
        .frame_counter (frame_counter),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .validity      (validity),
        .user          (user),
        .parity_err    (parity_err),
        .vout          (vout),
        .framing_err   (framing_err),
        .cs_word       (cs_word),
        .cs_valid      (cs_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vout)        n_vout++;
        if (framing_err) n_ferr++;
        if (cs_valid)    n_csv++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Even parity: P makes the XOR of all 28 bits zero; bad flips it.
    function automatic logic [27:0] mk_sf(input logic [23:0] s, input logic v, input logic u,
                                          input logic c, input logic bad);
        logic [26:0] b;
        b = {c, u, v, s};
        return {(^b) ^ bad, b};
    endfunction

    task automatic send_sf(input logic ch, input logic [7:0] fr, input logic [27:0] bits,
                           input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            channel       = ch;
            frame_counter = fr;
            din           = bits[i];
            vin           = 1'b1;
            @(negedge clk);
            vin           = 1'b0;
        end
    endtask

    task automatic send_pair(input logic [7:0] fr, input logic [23:0] ls, input logic lv,
                             input logic lu, input logic lc, input logic [23:0] rs,
                             input logic rv, input logic ru, input logic rbad);
        send_sf(1'b0, fr, mk_sf(ls, lv, lu, lc, 1'b0), 28);
        send_sf(1'b1, fr, mk_sf(rs, rv, ru, 1'b0, rbad), 28);
    endtask

    initial begin
        rst = 1'b1; vin = 1'b0; din = 1'b0; channel = 1'b0; frame_counter = 8'd0;
        cs_pat = 32'hA5A50F0F;
        repeat (3) @(negedge clk);
        chk("rst_samples", {sample_l, sample_r}, 64'd0);
        chk("rst_ctrl", {validity, user, parity_err, vout, framing_err, cs_word, cs_valid}, 64'd0);
        rst = 1'b0;

        e_v = n_vout; e_f = n_ferr;
        send_sf(1'b1, 8'd200, mk_sf(24'h111111, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        repeat (3) @(negedge clk);
        chk("orphan_ferr", 64'(n_ferr - e_f), 64'd1);
        chk("orphan_vout", 64'(n_vout - e_v), 64'd0);

        e_v = n_vout; e_f = n_ferr;
        send_pair(8'd200, 24'h123456, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
        #1;
        chk("pair1_latency", 64'(vout), 64'd1);
        repeat (3) @(negedge clk);
        chk("pair1_l", 64'(sample_l), 64'h123456);
        chk("pair1_r", 64'(sample_r), 64'hABCDEF);
        chk("pair1_v", 64'(validity), 64'd2);
        chk("pair1_u", 64'(user), 64'd1);
        chk("pair1_perr", 64'(parity_err), 64'd0);
        chk("pair1_vout", 64'(n_vout - e_v), 64'd1);
        chk("pair1_ferr", 64'(n_ferr - e_f), 64'd0);

        e_v = n_vout;
        send_pair(8'd200, 24'h123456, 1'b0, 1'b1, 1'b0, 24'hABCDEF, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("pair2_perr", 64'(parity_err), 64'd1);
        chk("pair2_l", 64'(sample_l), 64'h123456);
        chk("pair2_r", 64'(sample_r), 64'hABCDEF);
        chk("pair2_vout", 64'(n_vout - e_v), 64'd1);

        // Short left (20 bits) then a right: short error at the boundary, orphan error at its end.
        e_v = n_vout; e_f = n_ferr;
        send_sf(1'b0, 8'd200, mk_sf(24'h0F0F0F, 1'b1, 1'b1, 1'b0, 1'b0), 20);
        send_sf(1'b1, 8'd200, mk_sf(24'h222222, 1'b0, 1'b0, 1'b0, 1'b0), 28);
        repeat (3) @(negedge clk);
        chk("trunc_ferr", 64'(n_ferr - e_f), 64'd2);
        chk("trunc_vout", 64'(n_vout - e_v), 64'd0);
        chk("trunc_hold_l", 64'(sample_l), 64'h123456);

        e_v = n_vout; e_f = n_ferr;
        send_pair(8'd200, 24'h654321, 1'b1, 1'b1, 1'b0, 24'h0FEDCB, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("recov_l", 64'(sample_l), 64'h654321);
        chk("recov_r", 64'(sample_r), 64'h0FEDCB);
        chk("recov_v", 64'(validity), 64'd1);
        chk("recov_u", 64'(user), 64'd3);
        chk("recov_perr", 64'(parity_err), 64'd0);
        chk("recov_vout", 64'(n_vout - e_v), 64'd1);
        chk("recov_ferr", 64'(n_ferr - e_f), 64'd0);

        chk("cs_none_yet", 64'(n_csv), 64'd0);
        e_v = n_vout; e_c = n_csv;
        for (int f = 0; f < 32; f++) begin
            send_pair(8'(f), 24'(f * 3 + 1), 1'b0, 1'b0, cs_pat[f], 24'(f), 1'b0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk("cs_count", 64'(n_csv - e_c), 64'd1);
        chk("cs_word", 64'(cs_word), 64'hA5A50F0F);
        chk("cs_vout", 64'(n_vout - e_v), 64'd32);
        chk("cs_last_l", 64'(sample_l), 64'h5E);

        send_sf(1'b0, 8'd200, mk_sf(24'h777777, 1'b0, 1'b0, 1'b0, 1'b0), 12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_samples", {sample_l, sample_r}, 64'd0);
        chk("mrst_ctrl", {validity, user, parity_err, vout, framing_err, cs_word, cs_valid}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        e_v = n_vout; e_f = n_ferr;
        send_pair(8'd200, 24'h13579B, 1'b1, 1'b0, 1'b0, 24'h2468AC, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("mrst_vout", 64'(n_vout - e_v), 64'd1);
        chk("mrst_ferr", 64'(n_ferr - e_f), 64'd0);
        chk("mrst_l", 64'(sample_l), 64'h13579B);
        chk("mrst_r", 64'(sample_r), 64'h2468AC);
        chk("mrst_v", 64'(validity), 64'd1);
        chk("mrst_u", 64'(user), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
